uart_device: RTL and testbench
==============================

UART_DEVICE -- requirements
Module: uart_device

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (115200 baud at 50 MHz), legal range 8..65535.
REQ-002 Parameter FIFO_DEPTH, default 8, entries per RX and TX FIFO, power of two.
REQ-003 clk  input  1  sole clock; all state is on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 devaddr  input  2  bus device address, static.
REQ-006 in  input  32  command word from the bus output port.
REQ-007 out  output  32  status/data word to the bus input port.
REQ-008 irq  output  1  RX interrupt pulse to the CPU.
REQ-009 uart_rxd  input  1  serial receive line, asynchronous.
REQ-010 uart_txd  output  1  serial transmit line.

Function
REQ-011 Command format: in[31:30] target address, in[29:28] opcode, in[27] toggle, in[7:0] data; other bits ignored.
REQ-012 Command accepted in the cycle where in[31:30]==devaddr and in[27] differs from the stored toggle; stored toggle then takes in[27]; one command per toggle change, held words never repeat.
REQ-013 Opcodes: 00 NOP; 01 push in[7:0] into TX FIFO; 10 pop RX FIFO head; 11 clear sticky error flags.
REQ-014 Every command's effect is visible on out at the first rising edge after acceptance.
REQ-015 out layout: [7:0] RX head byte (0 when empty), [8] rx_empty, [9] rx_full, [10] tx_empty, [11] tx_full, [12] rx_overrun, [13] framing_err, [14] tx_overflow, [15] 0, [19:16] RX count, [23:20] TX count, [26:24] 0, [27] last accepted toggle, [29:28] 0, [31:30] devaddr.
REQ-016 out is fully registered; no combinational path from in or uart_rxd.
REQ-017 TX push when TX FIFO is full: byte dropped, tx_overflow set.
REQ-018 RX pop when RX FIFO is empty: no effect.
REQ-019 Sticky flags clear only on opcode 11 or reset; if clear and a new error occur in the same cycle, the flag stays set.
REQ-020 uart_rxd passes through a 2-flop synchronizer before use.
REQ-021 RX FSM states: IDLE, START, DATA, STOP.
REQ-022 IDLE -> START on synchronized falling edge; START samples at CLKS_PER_BIT/2; line high -> IDLE (glitch rejected), low -> DATA.
REQ-023 DATA samples 8 bits LSB first, one per CLKS_PER_BIT, at mid-bit; then STOP samples the stop bit at mid-bit.
REQ-024 Stop bit 1: byte pushed to RX FIFO, irq high for exactly one cycle; if FIFO full, byte discarded, rx_overrun set, no irq.
REQ-025 Stop bit 0: byte discarded, framing_err set, no irq; FSM returns to IDLE and waits for line high before the next start detection.
REQ-026 Simultaneous RX push and CPU pop: both occur, count unchanged, pop returns the old head.
REQ-027 TX FSM states: IDLE, START, DATA, STOP; uart_txd high in IDLE.
REQ-028 IDLE with TX FIFO non-empty: pop head, enter START the next cycle; start bit low begins within 2 cycles of the push when idle.
REQ-029 Each TX bit is held exactly CLKS_PER_BIT cycles: start 0, 8 data bits LSB first, stop 1.
REQ-030 After STOP, a non-empty FIFO goes straight to START with no extra idle bit; otherwise IDLE.
REQ-031 Simultaneous TX push by the CPU and pop by the TX FSM: both occur; push to a full FIFO in the same cycle as a pop succeeds.
REQ-032 FIFO pointers wrap modulo FIFO_DEPTH; counts span 0..FIFO_DEPTH.

Reset
REQ-033 rst low asynchronously forces both FSMs to IDLE, FIFOs empty, sticky flags 0, stored toggle 0, irq 0, uart_txd 1.
REQ-034 During reset out reads rx_empty=1, tx_empty=1, all else 0 except [31:30]=devaddr.
REQ-035 Reset mid-frame aborts it at once: TX line returns high with no partial byte; a partial RX byte is discarded.

Verification (CLKS_PER_BIT=16, devaddr=2'b11)
REQ-036 in=0xD8000055 once (toggle 1) -> uart_txd carries 0,1,0,1,0,1,0,1,0,1 with 16 cycles per bit; out[10] returns to 1.
REQ-037 Drive byte 0xA3 on uart_rxd with a valid stop bit -> one irq pulse; out[7:0]=0xA3, out[19:16]=1; pop with in=0xE0000000 -> out[8]=1.
REQ-038 Receive 9 bytes without popping -> count 8, out[12]=1, first 8 bytes intact; opcode 11 -> out[12]=0.
REQ-039 Byte with stop bit 0 -> out[13]=1, count unchanged, no irq; an 8-cycle low glitch -> no state change.
REQ-040 Write 9 bytes back-to-back while TX busy -> out[14]=1; 8 bytes transmitted contiguously; address 2'b01 or a repeated toggle is ignored.
REQ-041 Assert rst mid TX and mid RX frame -> uart_txd=1 at once, out matches REQ-034, next frame handled normally.

Source files
------------

// File: rtl/uart_device.sv
// Memory-mapped UART: toggle-handshaked command word in, registered status word out,
// 8N1 receiver and transmitter, each side buffered by a small FIFO.
module uart_device #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  devaddr,
    input  logic [31:0] in,
    output logic [31:0] out,
    output logic        irq,
    input  logic        uart_rxd,
    output logic        uart_txd
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] P1       = PW'(1);
    localparam logic [CW-1:0] C1       = CW'(1);
    localparam logic [CW-1:0] CFULL    = CW'(FIFO_DEPTH);
    localparam logic [15:0]   BIT_END  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0]   HALF_END = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        rx_state, rx_state_n, tx_state, tx_state_n;
    logic [15:0]   rx_clk, rx_clk_n, tx_clk, tx_clk_n;
    logic [2:0]    rx_bit, rx_bit_n, tx_bit, tx_bit_n;
    logic [7:0]    rx_shift, rx_shift_n, tx_shift, tx_shift_n;
    logic          rxd_s1, rxd_s2, rxd_prev;
    logic          rx_done, rx_ferr, tx_pop, txd_n;
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [PW-1:0] rx_rd, rx_wr, tx_rd, tx_wr, rx_rd_n, rx_wr_n, tx_rd_n, tx_wr_n;
    logic [CW-1:0] rx_cnt, tx_cnt, rx_cnt_n, tx_cnt_n;
    logic          ovr, ferr, txo, tog, ovr_n, ferr_n, txo_n, tog_n;
    logic          cmd_ok, cpu_push, cpu_pop, cpu_clr;
    logic          rx_pop_ok, rx_push_ok, tx_push_ok;
    logic [7:0]    rx_head_n;
    logic [29:0]   out_r, out_n;
    logic          unused_in;

    assign unused_in = ^in[26:8];
    assign out       = {devaddr, out_r};

    // Receiver: all sampling is on the synchronized line, mid-bit.
    always_comb begin
        rx_state_n = rx_state;
        rx_clk_n   = rx_clk + 16'd1;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_done    = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state)
            IDLE: begin
                rx_clk_n = '0;
                if (rxd_prev && !rxd_s2) rx_state_n = START;
            end
            START: if (rx_clk == HALF_END) begin
                rx_clk_n   = '0;
                rx_bit_n   = '0;
                rx_state_n = rxd_s2 ? IDLE : DATA;
            end
            DATA: if (rx_clk == BIT_END) begin
                rx_clk_n   = '0;
                rx_shift_n = {rxd_s2, rx_shift[7:1]};
                rx_bit_n   = rx_bit + 3'd1;
                if (rx_bit == 3'd7) rx_state_n = STOP;
            end
            STOP: if (rx_clk == BIT_END) begin
                rx_clk_n   = '0;
                rx_state_n = IDLE;
                rx_done    = rxd_s2;
                rx_ferr    = !rxd_s2;
            end
            default: rx_state_n = IDLE;
        endcase
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_clk_n   = tx_clk + 16'd1;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        case (tx_state)
            IDLE: begin
                tx_clk_n = '0;
                if (tx_cnt != '0) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_mem[tx_rd];
                    tx_state_n = START;
                end
            end
            START: if (tx_clk == BIT_END) begin
                tx_clk_n   = '0;
                tx_bit_n   = '0;
                tx_state_n = DATA;
            end
            DATA: if (tx_clk == BIT_END) begin
                tx_clk_n   = '0;
                tx_shift_n = {1'b0, tx_shift[7:1]};
                tx_bit_n   = tx_bit + 3'd1;
                if (tx_bit == 3'd7) tx_state_n = STOP;
            end
            STOP: if (tx_clk == BIT_END) begin
                tx_clk_n = '0;
                if (tx_cnt != '0) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_mem[tx_rd];
                    tx_state_n = START;
                end else begin
                    tx_state_n = IDLE;
                end
            end
            default: tx_state_n = IDLE;
        endcase
        txd_n = (tx_state_n == START) ? 1'b0 :
                (tx_state_n == DATA)  ? tx_shift_n[0] : 1'b1;
    end

    // Status word is built from next-state values so a command shows up one edge after acceptance.
    always_comb begin
        cmd_ok     = (in[31:30] == devaddr) && (in[27] != tog);
        cpu_push   = cmd_ok && (in[29:28] == 2'b01);
        cpu_pop    = cmd_ok && (in[29:28] == 2'b10);
        cpu_clr    = cmd_ok && (in[29:28] == 2'b11);
        tog_n      = cmd_ok ? in[27] : tog;
        rx_pop_ok  = cpu_pop && (rx_cnt != '0);
        rx_push_ok = rx_done && ((rx_cnt != CFULL) || rx_pop_ok);
        tx_push_ok = cpu_push && ((tx_cnt != CFULL) || tx_pop);
        rx_rd_n    = rx_pop_ok  ? rx_rd + P1 : rx_rd;
        rx_wr_n    = rx_push_ok ? rx_wr + P1 : rx_wr;
        tx_rd_n    = tx_pop     ? tx_rd + P1 : tx_rd;
        tx_wr_n    = tx_push_ok ? tx_wr + P1 : tx_wr;
        rx_cnt_n   = rx_cnt;
        if (rx_push_ok && !rx_pop_ok)      rx_cnt_n = rx_cnt + C1;
        else if (!rx_push_ok && rx_pop_ok) rx_cnt_n = rx_cnt - C1;
        tx_cnt_n   = tx_cnt;
        if (tx_push_ok && !tx_pop)         tx_cnt_n = tx_cnt + C1;
        else if (!tx_push_ok && tx_pop)    tx_cnt_n = tx_cnt - C1;
        ovr_n      = (ovr  & ~cpu_clr) | (rx_done & ~rx_push_ok);
        ferr_n     = (ferr & ~cpu_clr) | rx_ferr;
        txo_n      = (txo  & ~cpu_clr) | (cpu_push & ~tx_push_ok);
        // The new head may be the byte landing this cycle, not yet in memory.
        if (rx_cnt_n == '0)                        rx_head_n = '0;
        else if (rx_push_ok && (rx_rd_n == rx_wr)) rx_head_n = rx_shift;
        else                                       rx_head_n = rx_mem[rx_rd_n];
        out_n = {2'b00, tog_n, 3'b000, 4'(tx_cnt_n), 4'(rx_cnt_n), 1'b0, txo_n, ferr_n, ovr_n,
                 tx_cnt_n == CFULL, tx_cnt_n == '0, rx_cnt_n == CFULL, rx_cnt_n == '0, rx_head_n};
    end

    always_ff @(posedge clk) begin
        if (rx_push_ok) rx_mem[rx_wr] <= rx_shift;
        if (tx_push_ok) tx_mem[tx_wr] <= in[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= IDLE;  tx_state <= IDLE;
            rx_clk   <= '0;    tx_clk   <= '0;
            rx_bit   <= '0;    tx_bit   <= '0;
            rx_shift <= '0;    tx_shift <= '0;
            rxd_s1   <= 1'b1;  rxd_s2   <= 1'b1;  rxd_prev <= 1'b1;
            rx_rd    <= '0;    rx_wr    <= '0;    rx_cnt   <= '0;
            tx_rd    <= '0;    tx_wr    <= '0;    tx_cnt   <= '0;
            ovr      <= 1'b0;  ferr     <= 1'b0;  txo      <= 1'b0;  tog <= 1'b0;
            irq      <= 1'b0;  uart_txd <= 1'b1;
            out_r    <= 30'h500;
        end else begin
            rx_state <= rx_state_n;  tx_state <= tx_state_n;
            rx_clk   <= rx_clk_n;    tx_clk   <= tx_clk_n;
            rx_bit   <= rx_bit_n;    tx_bit   <= tx_bit_n;
            rx_shift <= rx_shift_n;  tx_shift <= tx_shift_n;
            rxd_s1   <= uart_rxd;    rxd_s2   <= rxd_s1;    rxd_prev <= rxd_s2;
            rx_rd    <= rx_rd_n;     rx_wr    <= rx_wr_n;   rx_cnt   <= rx_cnt_n;
            tx_rd    <= tx_rd_n;     tx_wr    <= tx_wr_n;   tx_cnt   <= tx_cnt_n;
            ovr      <= ovr_n;       ferr     <= ferr_n;    txo      <= txo_n;   tog <= tog_n;
            irq      <= rx_push_ok;  uart_txd <= txd_n;
            out_r    <= out_n;
        end
    end
endmodule

// File: tb/tb_uart_device.sv
// Directed bench for uart_device at 16 clocks per bit, device address 2'b11.
module tb_uart_device;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  devaddr = 2'b11;
    logic [31:0] in_w;
    logic [31:0] out_w;
    logic        irq;
    logic        rxd;
    logic        txd;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          irq_cnt = 0;
    int          base, gap, run;
    bit          seen;
    logic        tb_tog;
    logic [9:0]  fr;
    logic [7:0]  pushes [9] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};

    uart_device #(.CLKS_PER_BIT(16), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .devaddr(devaddr), .in(in_w), .out(out_w),
        .irq(irq), .uart_rxd(rxd), .uart_txd(txd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (irq === 1'b1) irq_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ew(input logic [7:0] head, input int rxc, input int txc,
                                       input logic ov, input logic fe, input logic to);
        ew = {2'b11, 2'b00, tb_tog, 3'b000, 4'(txc), 4'(rxc), 1'b0, to, fe, ov,
              txc == 8, txc == 0, rxc == 8, rxc == 0, head};
    endfunction

    task automatic cmd(input logic [1:0] op, input logic [7:0] data);
        @(negedge clk);
        tb_tog = ~tb_tog;
        in_w   = {2'b11, op, tb_tog, 19'b0, data};
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        @(negedge clk); rxd = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (16) @(negedge clk);
        end
        rxd = stop;
        repeat (16) @(negedge clk);
        rxd = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic tx_wait_fall(input int limit, output int g, output bit s);
        int k;
        s = 1'b0;
        for (k = 0; k <= limit; k++) begin
            if (txd === 1'b0) begin s = 1'b1; break; end
            @(negedge clk);
        end
        g = k;
    endtask

    task automatic tx_bits(input int first, input int nbits, output logic [9:0] f);
        f = '0;
        repeat (first) @(negedge clk);
        f[0] = txd;
        for (int i = 1; i < nbits; i++) begin
            repeat (16) @(negedge clk);
            f[i] = txd;
        end
    endtask

    initial begin
        rst = 1'b0; in_w = '0; rxd = 1'b1; tb_tog = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out", out_w, 32'hC000_0500);
        check("reset_irq", irq, 1'b0);
        check("reset_txd", txd, 1'b1);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // TX 0x55
        cmd(2'b01, 8'h55);
        check("tx_cmd_word", in_w, 32'hD800_0055);
        @(negedge clk);
        check("tx_push_out", out_w, 32'hC810_0100);
        tx_wait_fall(10, gap, seen);
        check("tx_start_seen", seen, 1'b1);
        run = 0;
        while (txd === 1'b0 && run < 100) begin @(negedge clk); run++; end
        check("tx_start_len", run, 16);
        tx_bits(7, 9, fr);
        check("tx_55_bits", fr[8:0], 9'h155);
        repeat (12) @(negedge clk);
        check("tx_done_out", out_w, ew(8'h00, 0, 0, 0, 0, 0));

        // RX 0xA3, then pop
        base = irq_cnt;
        rx_send(8'hA3, 1'b1);
        check("rx_a3_irq", irq_cnt - base, 1);
        check("rx_a3_out", out_w, 32'hC801_04A3);
        cmd(2'b10, 8'h00);
        check("pop_cmd_word", in_w, 32'hE000_0000);
        @(negedge clk);
        check("rx_pop_out", out_w, 32'hC000_0500);

        // RX overrun
        base = irq_cnt;
        for (int k = 0; k < 9; k++) rx_send(8'(8'h10 + k), 1'b1);
        check("ovr_irq", irq_cnt - base, 8);
        check("ovr_out", out_w, 32'hC008_1610);
        for (int k = 0; k < 8; k++) begin
            check("ovr_head", out_w[7:0], 8'(8'h10 + k));
            cmd(2'b10, 8'h00);
            @(negedge clk);
        end
        check("ovr_drained", out_w, ew(8'h00, 0, 0, 1, 0, 0));
        cmd(2'b11, 8'h00);
        @(negedge clk);
        check("ovr_cleared", out_w, ew(8'h00, 0, 0, 0, 0, 0));

        // Framing error and start glitch
        base = irq_cnt;
        rx_send(8'h5A, 1'b0);
        check("ferr_irq", irq_cnt - base, 0);
        check("ferr_out", out_w, ew(8'h00, 0, 0, 0, 1, 0));
        @(negedge clk); rxd = 1'b0;
        repeat (8) @(negedge clk); rxd = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_out", out_w, ew(8'h00, 0, 0, 0, 1, 0));
        check("glitch_irq", irq_cnt - base, 0);
        cmd(2'b11, 8'h00);
        @(negedge clk);
        check("ferr_cleared", out_w, ew(8'h00, 0, 0, 0, 0, 0));

        // TX overflow and back-to-back frames
        cmd(2'b01, 8'hFF);
        for (int k = 0; k < 9; k++) cmd(2'b01, pushes[k]);
        @(negedge clk);
        check("txo_out", out_w, ew(8'h00, 0, 8, 0, 0, 1));
        for (int i = 0; i < 100 && txd !== 1'b1; i++) @(negedge clk);
        tx_wait_fall(300, gap, seen);
        check("txo_first_seen", seen, 1'b1);
        for (int f = 0; f < 8; f++) begin
            tx_bits(8, 10, fr);
            check("txo_frame", fr, {1'b1, pushes[f], 1'b0});
            tx_wait_fall(300, gap, seen);
            if (f < 7) check("txo_gap", gap, 8);
            else       check("txo_no_ninth", seen, 1'b0);
        end
        check("txo_done_out", out_w, ew(8'h00, 0, 0, 0, 0, 1));

        // Foreign address and repeated toggle are ignored
        @(negedge clk); in_w = {2'b01, 2'b01, ~tb_tog, 19'b0, 8'h77};
        repeat (2) @(negedge clk);
        check("ign_addr", out_w, ew(8'h00, 0, 0, 0, 0, 1));
        in_w = {2'b11, 2'b01, tb_tog, 19'b0, 8'h66};
        repeat (2) @(negedge clk);
        check("ign_toggle", out_w, ew(8'h00, 0, 0, 0, 0, 1));
        tx_wait_fall(20, gap, seen);
        check("ign_txd_idle", seen, 1'b0);
        cmd(2'b11, 8'h00);
        @(negedge clk);
        check("txo_cleared", out_w, ew(8'h00, 0, 0, 0, 0, 0));

        // Reset in the middle of both frames
        @(negedge clk); rxd = 1'b0;
        cmd(2'b01, 8'h3C);
        repeat (15) @(negedge clk); rxd = 1'b1;
        repeat (16) @(negedge clk); rxd = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_txd_low", txd, 1'b0);
        in_w = '0;
        #2 rst = 1'b0;
        #1;
        check("mid_rst_txd", txd, 1'b1);
        check("mid_rst_out", out_w, 32'hC000_0500);
        check("mid_rst_irq", irq, 1'b0);
        @(negedge clk); rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1; tb_tog = 1'b0;
        base = irq_cnt;
        repeat (20) @(negedge clk);
        check("post_rst_out", out_w, 32'hC000_0500);
        check("post_rst_txd", txd, 1'b1);
        rx_send(8'h5C, 1'b1);
        check("post_rx_irq", irq_cnt - base, 1);
        check("post_rx_out", out_w, 32'hC001_045C);
        cmd(2'b01, 8'hA5);
        tx_wait_fall(10, gap, seen);
        check("post_tx_seen", seen, 1'b1);
        tx_bits(8, 10, fr);
        check("post_tx_frame", fr, {1'b1, 8'hA5, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
